// File: rtl/npc_wbu.sv
// Writeback unit: accepts one EXU result per handshake, runs loads through the
// data-memory port with sign/zero extension, and issues a one-cycle RF write.
module npc_wbu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd_addr,
    input  logic             in_rd_wen,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_data,
    output logic             rf_we,
    output logic [4:0]       rf_rd_addr,
    output logic [WIDTH-1:0] rf_rd_data,
    output logic             commit,
    output logic             load_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]       state_q,  state_d;
    logic [4:0]       rd_q,     rd_d;
    logic             wen_q,    wen_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             fault_q,  fault_d;

    // Misaligned halves/words and the unused funct3 codes all trap.
    function automatic logic load_is_fault(input logic [2:0] f3, input logic [1:0] b);
        logic flt;
        case (f3)
            F3_LB, F3_LBU: flt = 1'b0;
            F3_LH, F3_LHU: flt = b[0];
            F3_LW:         flt = (b != 2'b00);
            default:       flt = 1'b1;
        endcase
        return flt;
    endfunction

    function automatic logic [WIDTH-1:0] load_extract(
        input logic [2:0]       f3,
        input logic [1:0]       b,
        input logic [WIDTH-1:0] data
    );
        logic [7:0]       byte_v;
        logic [15:0]      half_v;
        logic [WIDTH-1:0] res;
        byte_v = data[{b, 3'b000} +: 8];
        half_v = data[{b[1], 4'b0000} +: 16];
        case (f3)
            F3_LB:   res = {{(WIDTH-8){byte_v[7]}}, byte_v};
            F3_LBU:  res = {{(WIDTH-8){1'b0}}, byte_v};
            F3_LH:   res = {{(WIDTH-16){half_v[15]}}, half_v};
            F3_LHU:  res = {{(WIDTH-16){1'b0}}, half_v};
            default: res = data;
        endcase
        return res;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and a latch is never inferred.
        state_d  = state_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        result_d = result_q;
        funct3_d = funct3_q;
        fault_d  = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_d     = in_rd_addr;
                    wen_d    = in_rd_wen;
                    result_d = in_result;
                    funct3_d = in_funct3;
                    fault_d  = 1'b0;
                    state_d  = ST_WB;
                    if (in_is_load) begin
                        if (load_is_fault(in_funct3, in_result[1:0])) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
            end
            ST_REQ: begin
                // A response in the handshake cycle is not taken; it must arrive in WAIT.
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    result_d = load_extract(funct3_q, result_q[1:0], mem_rsp_data);
                    state_d  = ST_WB;
                end
            end
            default: begin
                fault_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            result_q <= '0;
            funct3_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            result_q <= result_d;
            funct3_q <= funct3_d;
            fault_q  <= fault_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = {result_q[WIDTH-1:2], 2'b00};
    assign commit        = (state_q == ST_WB);
    assign load_fault    = commit & fault_q;
    assign rf_we         = commit & wen_q & (rd_q != 5'd0) & ~fault_q;
    assign rf_rd_addr    = rd_q;
    assign rf_rd_data    = result_q;

endmodule

// File: tb/tb_npc_wbu.sv
// Directed bench for npc_wbu: expected writebacks go into a scoreboard queue
// when an instruction is driven and are compared when commit appears.
module tb_npc_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic        in_rd_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        commit;
    logic        load_fault;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    npc_wbu #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd_addr    (in_rd_addr),
        .in_rd_wen     (in_rd_wen),
        .in_result     (in_result),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rf_we         (rf_we),
        .rf_rd_addr    (rf_rd_addr),
        .rf_rd_data    (rf_rd_data),
        .commit        (commit),
        .load_fault    (load_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load behaviour written with shifts, independent of the RTL slicing.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b[7]  ? (b | 32'hFFFF_FF00) : b);
            3'b100:  return b;
            3'b001:  return (h[15] ? (h | 32'hFFFF_0000) : h);
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic ref_fault(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return addr[0];
        if (f3 == 3'b010) return (addr[1:0] != 2'b00);
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle; returns after the accepting posedge.
    task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                        input logic is_load, input logic [2:0] f3);
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_rd_addr = rd;
        in_rd_wen  = wen;
        in_result  = res;
        in_is_load = is_load;
        in_funct3  = f3;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_result  = 32'h0BAD_0BAD;
    endtask

    task automatic wait_commit(input string tag, input int lat_exp);
        int   n    = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (commit === 1'b1) seen = 1'b1;
        end
        check({tag, "_commit_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(n), 32'(lat_exp));
            if (sb.size() == 0) begin
                check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check({tag, "_rf_we"}, 32'(rf_we), 32'(e.we));
                check({tag, "_load_fault"}, 32'(load_fault), 32'(e.fault));
                check({tag, "_mem_req_idle"}, 32'(mem_req_valid), 32'd0);
                if (e.we) begin
                    check({tag, "_rf_addr"}, 32'(rf_rd_addr), 32'(e.addr));
                    check({tag, "_rf_data"}, rf_rd_data, e.data);
                end
            end
        end
        @(negedge clk);
        check({tag, "_commit_pulse"}, 32'(commit), 32'd0);
        check({tag, "_rf_we_pulse"}, 32'(rf_we), 32'd0);
    endtask

    task automatic do_alu(input string tag, input logic [4:0] rd, input logic wen,
                          input logic [31:0] res);
        exp_t e;
        e.we = wen && (rd != 5'd0); e.addr = rd; e.data = res; e.fault = 1'b0;
        sb.push_back(e);
        send(rd, wen, res, 1'b0, 3'b000);
        wait_commit(tag, 1);
    endtask

    task automatic do_fault(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [2:0] f3);
        exp_t e;
        e.we = 1'b0; e.addr = rd; e.data = 32'd0; e.fault = 1'b1;
        sb.push_back(e);
        send(rd, 1'b1, addr, 1'b1, f3);
        wait_commit(tag, 1);
    endtask

    // ready_dly: cycles REQ is held with ready low; rsp_dly: WAIT cycles before rsp.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] word,
                           input int ready_dly, input int rsp_dly, input bit early_rsp);
        exp_t e;
        e.we = (rd != 5'd0); e.addr = rd; e.data = ref_load(f3, addr, word);
        e.fault = ref_fault(f3, addr);
        sb.push_back(e);
        send(rd, 1'b1, addr, 1'b1, f3);
        for (int i = 0; i <= ready_dly; i++) begin
            @(negedge clk);
            check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
            check({tag, "_req_addr"}, mem_req_addr, addr & 32'hFFFF_FFFC);
            check({tag, "_busy"}, 32'(in_ready), 32'd0);
        end
        mem_req_ready = 1'b1;
        if (early_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h5555_5555;
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            check({tag, "_wait_no_req"}, 32'(mem_req_valid), 32'd0);
            check({tag, "_wait_no_commit"}, 32'(commit), 32'd0);
            check({tag, "_wait_busy"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        wait_commit(tag, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd_addr = '0; in_rd_wen = 1'b0;
        in_result = '0; in_is_load = 1'b0; in_funct3 = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req_valid), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_load_fault", 32'(load_fault), 32'd0);
        check("rst_rf_addr", 32'(rf_rd_addr), 32'd0);
        check("rst_rf_data", rf_rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_alu("alu_rd5", 5'd5, 1'b1, 32'hDEAD_BEEF);
        do_alu("alu_x0", 5'd0, 1'b1, 32'h1234_5678);
        do_alu("alu_nowen", 5'd7, 1'b0, 32'hCAFE_F00D);
        do_alu("alu_rd31", 5'd31, 1'b1, 32'h0000_0001);

        do_load("lb", 5'd10, 32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 0, 1'b0);
        do_load("lbu", 5'd11, 32'h0000_1003, 3'b100, 32'h80FF_1234, 0, 0, 1'b0);
        do_load("lhu", 5'd12, 32'h0000_1002, 3'b101, 32'h80FF_1234, 0, 0, 1'b0);
        do_load("lh", 5'd13, 32'h0000_1002, 3'b001, 32'h80FF_1234, 0, 0, 1'b0);
        do_load("lw", 5'd14, 32'h0000_2000, 3'b010, 32'h89AB_CDEF, 0, 0, 1'b0);
        do_load("lb_b1", 5'd15, 32'h0000_2001, 3'b000, 32'h0000_7F00, 0, 1, 1'b0);
        do_load("lw_x0", 5'd0, 32'h0000_3004, 3'b010, 32'hFFFF_FFFF, 0, 0, 1'b0);

        do_fault("flt_lw_b2", 5'd6, 32'h0000_4002, 3'b010);
        do_fault("flt_lh_b1", 5'd6, 32'h0000_4001, 3'b001);
        do_fault("flt_f3_011", 5'd6, 32'h0000_4000, 3'b011);
        do_fault("flt_f3_111", 5'd6, 32'h0000_4000, 3'b111);

        // Backpressure, plus a response in the REQ handshake cycle that must be ignored.
        do_load("bp", 5'd20, 32'h0000_5002, 3'b101, 32'hA5A5_8001, 3, 4, 1'b1);

        // Stray response while idle.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_commit", 32'(commit), 32'd0);
            check("stray_rf_we", 32'(rf_we), 32'd0);
            check("stray_ready", 32'(in_ready), 32'd1);
        end
        mem_rsp_valid = 1'b0;

        // Reset while waiting for the response drops the instruction.
        send(5'd9, 1'b1, 32'h0000_6000, 1'b1, 3'b010);
        @(negedge clk);
        check("rstw_req", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        check("rstw_mem_req", 32'(mem_req_valid), 32'd0);
        check("rstw_rf_addr", 32'(rf_rd_addr), 32'd0);
        check("rstw_rf_data", rf_rd_data, 32'd0);
        check("rstw_commit", 32'(commit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_2222;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rsp_commit", 32'(commit), 32'd0);
            check("late_rsp_rf_we", 32'(rf_we), 32'd0);
        end

        do_alu("alu_after_rst", 5'd3, 1'b1, 32'h0F0F_0F0F);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
